alu_instr_encoder: RTL and testbench

Pipelined encoder that does the reverse of the ALU decode path: it turns an ALU/branch operation request (`alu_control_t` plus `invert_cond` and register/immediate fields) into a legal 32-bit RV32 instruction word. It streams encoded words, each with an auto-incrementing byte address, toward the instruction-memory loader. The self-test program generator and bring-up loader use it, so a test can be written in `alu_control_t` terms. Requests that cannot be encoded are dropped and counted.

---
 rtl/alu_instr_encoder.sv | 178 +++++++++++++++++
 tb/tb_alu_instr_encoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_encoder.sv
// Encodes ALU/branch operation requests into RV32 instruction words and streams
// them out with an auto-incrementing byte address; unencodable requests are dropped and counted.
module alu_instr_encoder #(
  parameter int unsigned         ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [3:0]        in_alu_control,
  input  logic              in_invert_cond,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              addr_load,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic [7:0]        err_count
);

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_XY_ADD = 4'd10,
    ALU_XY_SUB = 4'd11,
    ALU_NOOP   = 4'd12,
    ALU_A      = 4'd13,
    ALU_B      = 4'd14,
    ALU_EQUAL  = 4'd15
  } alu_control_t;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  alu_control_t      op;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [2:0]        br_funct3;
  logic              enc_legal;
  logic [31:0]       enc_instr;
  logic              accept;
  logic [ADDR_W-1:0] addr_eff;

  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_pulse_q, err_pulse_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  assign op = alu_control_t'(in_alu_control);

  always_comb begin
    funct3 = 3'b000;
    funct7 = 7'b0000000;
    unique case (op)
      ALU_SLL:  funct3 = 3'b001;
      ALU_SLT:  funct3 = 3'b010;
      ALU_SLTU: funct3 = 3'b011;
      ALU_XOR:  funct3 = 3'b100;
      ALU_SRL:  funct3 = 3'b101;
      ALU_SRA:  funct3 = 3'b101;
      ALU_OR:   funct3 = 3'b110;
      ALU_AND:  funct3 = 3'b111;
      default:  funct3 = 3'b000;
    endcase
    unique case (op)
      ALU_SUB, ALU_SRA: funct7 = 7'b0100000;
      ALU_XY_ADD:       funct7 = 7'b1000000;
      ALU_XY_SUB:       funct7 = 7'b1100000;
      default:          funct7 = 7'b0000000;
    endcase
  end

  always_comb begin
    enc_legal = 1'b0;
    enc_instr = '0;
    br_funct3 = 3'b000;
    unique case (in_kind)
      2'd0: begin
        enc_legal = !(op inside {ALU_NOOP, ALU_A, ALU_B, ALU_EQUAL});
        enc_instr = {funct7, in_rs2, in_rs1, funct3, in_rd, OPC_R};
      end
      2'd1: begin
        if (op inside {ALU_SLL, ALU_SRL, ALU_SRA}) begin
          // Shift amount must be 0..31, so the upper immediate bits must all be zero
          enc_legal = (in_imm[12:5] == '0);
          enc_instr = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, OPC_I};
        end else if (op inside {ALU_ADD, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND}) begin
          enc_legal = (in_imm[12] == in_imm[11]);
          enc_instr = {in_imm[11:0], in_rs1, funct3, in_rd, OPC_I};
        end
      end
      2'd2: begin
        unique case (op)
          ALU_EQUAL: br_funct3 = {2'b00, in_invert_cond};
          ALU_SLT:   br_funct3 = {2'b10, in_invert_cond};
          ALU_SLTU:  br_funct3 = {2'b11, in_invert_cond};
          default:   br_funct3 = 3'b000;
        endcase
        enc_legal = (op inside {ALU_EQUAL, ALU_SLT, ALU_SLTU}) && !in_imm[0];
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, br_funct3,
                     in_imm[4:1], in_imm[11], OPC_B};
      end
      default: begin
        enc_legal = 1'b0;
        enc_instr = '0;
      end
    endcase
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // A reload while empty also redirects a request accepted in the same cycle
  assign addr_eff = (addr_load && !valid_q) ? BASE_ADDR : cnt_q;

  always_comb begin
    valid_d     = valid_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (addr_load && !valid_q) cnt_d = BASE_ADDR;
    if (accept) begin
      if (enc_legal) begin
        valid_d = 1'b1;
        instr_d = enc_instr;
        addr_d  = addr_eff;
        cnt_d   = addr_eff + ADDR_W'(4);
      end else begin
        err_pulse_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      instr_q     <= '0;
      addr_q      <= '0;
      cnt_q       <= BASE_ADDR;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Self-checking bench for alu_instr_encoder: directed and random requests compared
// against an arithmetic reference encoder, using a 16-bit and a wrapping 8-bit instance.
module tb_alu_instr_encoder;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_SLL = 2, OP_SLT = 3, OP_SLTU = 4,
                 OP_XOR = 5, OP_SRL = 6, OP_SRA = 7, OP_OR = 8, OP_AND = 9,
                 OP_XYADD = 10, OP_XYSUB = 11, OP_NOOP = 12, OP_A = 13, OP_B = 14,
                 OP_EQUAL = 15;
  localparam int BASE1 = 'h100;
  localparam int BASE2 = 'hF0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_kind;
  logic [3:0]  in_alu_control;
  logic        in_invert_cond;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [12:0] in_imm;
  logic        addr_load;
  logic        out_ready;

  logic        in_ready, out_valid, err_pulse;
  logic [31:0] out_instr;
  logic [15:0] out_addr;
  logic [7:0]  err_count;

  logic        in_ready_b, out_valid_b, err_pulse_b;
  logic [31:0] out_instr_b;
  logic [7:0]  out_addr_b;
  logic [7:0]  err_count_b;

  int checks = 0;
  int errors = 0;

  int   cnt1, cnt2, errs;
  bit   mv;
  logic [31:0] m_instr;
  int   m_addr1, m_addr2;
  bit   load_req;

  always #5 clk = ~clk;

  alu_instr_encoder #(.ADDR_W(16), .BASE_ADDR(16'h0100)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_alu_control(in_alu_control), .in_invert_cond(in_invert_cond),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .addr_load(addr_load), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err_pulse(err_pulse), .err_count(err_count)
  );

  alu_instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'hF0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_kind(in_kind), .in_alu_control(in_alu_control), .in_invert_cond(in_invert_cond),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .addr_load(addr_load), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_instr(out_instr_b), .out_addr(out_addr_b), .err_pulse(err_pulse_b),
    .err_count(err_count_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input int kind, input int op, input int imm);
    if (kind == 0) return op <= OP_XYSUB;
    if (kind == 1) begin
      if (op == OP_SLL || op == OP_SRL || op == OP_SRA) return imm >= 0 && imm <= 31;
      if (op == OP_ADD || op == OP_SLT || op == OP_SLTU || op == OP_XOR ||
          op == OP_OR || op == OP_AND) return imm >= -2048 && imm <= 2047;
      return 0;
    end
    if (kind == 2)
      return (op == OP_EQUAL || op == OP_SLT || op == OP_SLTU) && ((imm & 1) == 0);
    return 0;
  endfunction

  function automatic logic [31:0] ref_word(input int kind, input int op, input int inv,
                                           input int rd, input int rs1, input int rs2,
                                           input int imm);
    int f3tab [16] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7, 0, 0, 0, 0, 0, 0};
    int f3, f7, u, bf3, imm12;
    longint w;
    f3 = f3tab[op];
    f7 = (op == OP_SUB || op == OP_SRA) ? 32 : (op == OP_XYADD) ? 64 : (op == OP_XYSUB) ? 96 : 0;
    w = 0;
    if (kind == 0) begin
      w = (longint'(f7) << 25) + (longint'(rs2) << 20) + (longint'(rs1) << 15) +
          (longint'(f3) << 12) + (longint'(rd) << 7) + 51;
    end else if (kind == 1) begin
      if (op == OP_SLL || op == OP_SRL || op == OP_SRA) imm12 = f7 * 32 + imm;
      else imm12 = (imm + 4096) % 4096;
      w = (longint'(imm12) << 20) + (longint'(rs1) << 15) + (longint'(f3) << 12) +
          (longint'(rd) << 7) + 19;
    end else begin
      u   = (imm + 8192) % 8192;
      bf3 = ((op == OP_EQUAL) ? 0 : (op == OP_SLT) ? 4 : 6) + inv;
      w = (longint'((u / 4096) % 2) << 31) + (longint'((u / 32) % 64) << 25) +
          (longint'(rs2) << 20) + (longint'(rs1) << 15) + (longint'(bf3) << 12) +
          (longint'((u / 2) % 16) << 8) + (longint'((u / 2048) % 2) << 7) + 99;
    end
    return w[31:0];
  endfunction

  task automatic model_reset();
    cnt1 = BASE1; cnt2 = BASE2; errs = 0; mv = 0;
  endtask

  task automatic model_accept(input int kind, input int op, input int inv, input int rd,
                              input int rs1, input int rs2, input int imm);
    bit ok;
    ok = ref_legal(kind, op, imm);
    if (load_req && !mv) begin cnt1 = BASE1; cnt2 = BASE2; end
    if (ok) begin
      m_instr = ref_word(kind, op, inv, rd, rs1, rs2, imm);
      m_addr1 = cnt1; m_addr2 = cnt2;
      cnt1 = (cnt1 + 4) % 65536;
      cnt2 = (cnt2 + 4) % 256;
      mv = 1;
    end else begin
      if (errs < 255) errs++;
      mv = 0;
    end
    chk("valid", out_valid, mv);
    chk("valid_b", out_valid_b, mv);
    chk("err_pulse", err_pulse, !ok);
    chk("err_count", err_count, errs);
    if (ok) begin
      chk("instr", out_instr, m_instr);
      chk("addr", out_addr, m_addr1);
      chk("instr_b", out_instr_b, m_instr);
      chk("addr_b", out_addr_b, m_addr2);
    end
  endtask

  task automatic drive(input int kind, input int op, input int inv, input int rd,
                       input int rs1, input int rs2, input int imm);
    in_kind        = 2'(kind);
    in_alu_control = 4'(op);
    in_invert_cond = 1'(inv);
    in_rd          = 5'(rd);
    in_rs1         = 5'(rs1);
    in_rs2         = 5'(rs2);
    in_imm         = 13'(imm);
    in_valid       = 1'b1;
  endtask

  task automatic send(input int kind, input int op, input int inv, input int rd,
                      input int rs1, input int rs2, input int imm);
    int t;
    @(negedge clk);
    drive(kind, op, inv, rd, rs1, rs2, imm);
    addr_load = load_req;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    chk("accept_wait", 32'(t < 50), 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    addr_load = 1'b0;
    model_accept(kind, op, inv, rd, rs1, rs2, imm);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid  = 1'b0;
    addr_load = load_req;
    @(posedge clk); #1;
    if (load_req && !mv) begin cnt1 = BASE1; cnt2 = BASE2; end
    if (out_ready) mv = 0;
    addr_load = 1'b0;
    chk("idle_valid", out_valid, mv);
    chk("idle_pulse", err_pulse, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_instr"}, out_instr, 0);
    chk({tag, "_addr"}, out_addr, 0);
    chk({tag, "_pulse"}, err_pulse, 0);
    chk({tag, "_errcnt"}, err_count, 0);
    chk({tag, "_valid_b"}, out_valid_b, 0);
    chk({tag, "_addr_b"}, out_addr_b, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held_instr;
    logic [15:0] held_addr;
    int k, kind, op, imm;

    rst_n = 1'b0; in_valid = 1'b0; in_kind = '0; in_alu_control = '0;
    in_invert_cond = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    addr_load = 1'b0; out_ready = 1'b1; load_req = 0;
    model_reset();
    #2;
    check_reset_outputs("reset");
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    send(0, OP_ADD, 0, 3, 1, 2, 0);
    chk("add_word", out_instr, 32'h002081B3);
    chk("add_addr", out_addr, 32'h100);
    send(0, OP_SUB, 0, 3, 1, 2, 0);
    chk("sub_word", out_instr, 32'h402081B3);
    chk("sub_addr", out_addr, 32'h104);
    send(1, OP_SRA, 0, 5, 6, 0, 7);
    chk("srai_word", out_instr, 32'h40735293);
    chk("srai_addr", out_addr, 32'h108);

    send(2, OP_EQUAL, 1, 0, 1, 2, -8);
    chk("bne_word", out_instr, 32'hFE209CE3);
    chk("wrap_addr_fc", out_addr_b, 32'hFC);
    send(2, OP_SLTU, 0, 0, 3, 4, 16);
    chk("bltu_funct3", out_instr[14:12], 32'h6);
    chk("wrap_addr_00", out_addr_b, 32'h00);
    send(2, OP_EQUAL, 0, 0, 1, 2, 3);
    chk("odd_branch_errcnt", err_count, 1);
    send(0, OP_ADD, 0, 7, 8, 9, 0);
    chk("after_drop_addr", out_addr, 32'h114);

    send(1, OP_SUB, 0, 1, 2, 0, 5);
    send(1, OP_ADD, 0, 1, 2, 0, 2048);
    send(1, OP_SLL, 0, 1, 2, 0, 32);
    send(3, OP_ADD, 0, 1, 2, 3, 0);
    chk("illegal_errcnt", err_count, 5);

    for (int i = 0; i < 120; i++) begin
      k    = $urandom_range(0, 9);
      kind = (k < 4) ? 0 : (k < 7) ? 1 : (k < 9) ? 2 : 3;
      op   = $urandom_range(0, 15);
      imm  = $urandom_range(0, 1) ? int'($urandom_range(0, 40)) - 4
                                  : int'($urandom_range(0, 8191)) - 4096;
      send(kind, op, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), imm);
    end

    send(0, OP_AND, 0, 10, 11, 12, 0);
    held_instr = out_instr;
    held_addr  = out_addr;
    @(negedge clk);
    out_ready = 1'b0;
    drive(0, OP_XOR, 0, 13, 14, 15, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_instr", out_instr, held_instr);
      chk("bp_addr", out_addr, held_addr);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_accept(0, OP_XOR, 0, 13, 14, 15, 0);
    chk("bp_release_addr", out_addr, 32'(held_addr) + 4);
    for (int i = 0; i < 4; i++) send(0, OP_OR, 0, i, i + 1, i + 2, 0);

    @(negedge clk);
    out_ready = 1'b0;
    addr_load = 1'b1;
    @(posedge clk); #1;
    addr_load = 1'b0;
    chk("load_busy_valid", out_valid, 1);
    chk("load_busy_addr", out_addr, m_addr1);
    @(negedge clk);
    out_ready = 1'b1;
    send(0, OP_SLT, 0, 1, 1, 1, 0);
    idle();
    load_req = 1;
    idle();
    load_req = 0;
    send(0, OP_SLTU, 0, 2, 2, 2, 0);
    chk("load_empty_addr", out_addr, 32'h100);
    idle();
    load_req = 1;
    send(1, OP_XOR, 0, 3, 3, 0, -1);
    load_req = 0;
    chk("load_accept_addr", out_addr, 32'h100);
    send(1, OP_OR, 0, 4, 4, 0, 100);
    chk("load_accept_next", out_addr, 32'h104);

    for (int i = 0; i < 260; i++) send(3, OP_ADD, 0, 0, 0, 0, 0);
    chk("err_saturate", err_count, 255);

    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset2");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) send(3, OP_SUB, 0, 0, 0, 0, 0);
    send(0, OP_ADD, 0, 1, 2, 3, 0);
    chk("pre_reset_errcnt", err_count, 3);
    chk("pre_reset_valid", out_valid, 1);
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(0, OP_ADD, 0, 3, 1, 2, 0);
    chk("post_reset_addr", out_addr, 32'h100);
    chk("post_reset_addr_b", out_addr_b, 32'hF0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
